// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between
// instruction fetch (I) and load/store (D). D normally wins, but a starvation
// counter forces a fetch grant after STARVE_LIMIT data grants that bypassed a
// waiting fetch. A fetch flushed while in flight still completes on the memory
// side, but its acknowledge and read data are discarded.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(STARVE_LIMIT);
  localparam logic [31:0]      WORD_MASK = 32'hFFFF_FFFC;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] starve_cnt;
  logic             drop;
  logic             i_elig;
  logic             d_elig;
  logic             grant_i;
  logic             grant_d;

  // Eligibility, grant decision and next state; a requester whose ack is high
  // this cycle has not advanced its address yet, so it sits out one cycle.
  always_comb begin
    i_elig     = if_req && !if_ack;
    d_elig     = d_req && !d_ack;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        if (d_elig && !(i_elig && (starve_cnt == LIMIT))) begin
          grant_d    = 1'b1;
          state_next = BUSY_D;
        end else if (i_elig && !if_flush) begin
          grant_i    = 1'b1;
          state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any outstanding transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Memory-side request registers, acknowledge pulses, read data and flush drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
      drop     <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr & WORD_MASK;
            m_wdata <= d_wdata;
          end else if (grant_i) begin
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= if_addr & WORD_MASK;
            m_wdata <= '0;
          end
        end
        BUSY_I: begin
          if (m_ready) begin
            m_req <= 1'b0;
            m_we  <= 1'b0;
            drop  <= 1'b0;
            if (!(drop || if_flush)) begin
              if_ack   <= 1'b1;
              if_rdata <= m_rdata;
            end
          end else if (if_flush) begin
            drop <= 1'b1;
          end
        end
        BUSY_D: begin
          if (m_ready) begin
            m_req <= 1'b0;
            m_we  <= 1'b0;
            d_ack <= 1'b1;
            if (!m_we) begin
              d_rdata <= m_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Starvation counter: counts data grants that overtook a waiting fetch and
  // restarts whenever fetch is served or stops waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_d && i_elig) begin
        if (starve_cnt != LIMIT) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end else if (grant_i || !i_elig) begin
        starve_cnt <= '0;
      end
    end
  end

endmodule
